// File: rtl/reg_pkg.sv
// reg_pkg: shared register-stage types for the issue-side scoreboard.
// Provides the architectural register address type, pending-write counter
// type/limits and the scoreboard FSM state encoding.
package reg_pkg;

  // Architectural register file geometry.
  localparam int REG_NUM  = 32;
  localparam int REG_BITS = $clog2(REG_NUM);
  typedef logic [REG_BITS-1:0] reg_t;

  // Outstanding-write tracking per register.
  localparam int SB_MAX_PEND = 3;
  localparam int SB_CNT_BITS = $clog2(SB_MAX_PEND + 1);
  typedef logic [SB_CNT_BITS-1:0] sb_cnt_t;

  // Scoreboard control state: normal issue, or holding behind a branch.
  typedef enum logic {
    SB_RUN    = 1'b0,
    SB_BRANCH = 1'b1
  } sb_state_t;

endpackage

// File: rtl/reg_pend_cnt.sv
// reg_pend_cnt: saturating up/down counter of pending writes for one register.
// Ports: clk/rst (async active-high), inc_i (allocation), dec_i (retirement),
//        cnt_o (registered count), underflow_o (dec_i while count is zero).
module reg_pend_cnt #(
  parameter int MAX = 3,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         underflow_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         do_inc;
  logic         do_dec;

  // A retirement against an empty counter is dropped (and reported), so the
  // count never wraps below zero; likewise it never exceeds MAX.
  assign do_inc      = inc_i && (cnt_q != W'(MAX));
  assign do_dec      = dec_i && (cnt_q != '0);
  assign underflow_o = dec_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (do_inc && !do_dec) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_dec && !do_inc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-side RAW/WAW-saturation hazard and branch-hold control.
// Ports: clk/rst (async active-high); decoder request dec_* with issue_ready
//        (fire = dec_valid & issue_ready); writeback wb_valid/wb_addr and
//        wb_branch_done; status busy and sticky sb_err.
module reg_scoreboard
  import reg_pkg::*;
#(
  parameter int REG_NUM     = reg_pkg::REG_NUM,
  parameter int MAX_PEND    = SB_MAX_PEND,
  parameter bit ZERO_REG_HW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  // Decoder side
  input  logic dec_valid,
  input  reg_t dec_src1,
  input  reg_t dec_src2,
  input  logic dec_src1_used,
  input  logic dec_src2_used,
  input  logic dec_wb_wr,
  input  reg_t dec_dst,
  input  logic dec_branch,
  output logic issue_ready,
  // Writeback side
  input  logic wb_valid,
  input  reg_t wb_addr,
  input  logic wb_branch_done,
  // Status
  output logic busy,
  output logic sb_err
);

  localparam int CW = $clog2(MAX_PEND + 1);

  sb_state_t        state_q;
  sb_state_t        state_d;
  logic             err_q;
  logic             err_d;

  logic [CW-1:0]    pend [REG_NUM];
  logic [REG_NUM-1:0] nz;
  logic [REG_NUM-1:0] uf;

  logic             fire;
  logic             src1_haz;
  logic             src2_haz;
  logic             dst_full;

  // ---------------------------------------------------------------------------
  // Per-register pending-write counters. With ZERO_REG_HW the r0 slot is a
  // hard zero: it never allocates, never stalls and never flags underflow.
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < REG_NUM; r++) begin : g_cnt
    if (ZERO_REG_HW && (r == 0)) begin : g_zero
      assign pend[r] = '0;
      assign uf[r]   = 1'b0;
    end else begin : g_live
      reg_pend_cnt #(
        .MAX (MAX_PEND),
        .W   (CW)
      ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .inc_i       (fire && dec_wb_wr && (dec_dst == reg_t'(r))),
        .dec_i       (wb_valid && (wb_addr == reg_t'(r))),
        .cnt_o       (pend[r]),
        .underflow_o (uf[r])
      );
    end
    assign nz[r] = (pend[r] != '0);
  end

  // ---------------------------------------------------------------------------
  // Hazard compare. Only registered counters are consulted: a same-cycle
  // writeback lands in the register file at the edge, so it cannot release
  // a dependent instruction until the following cycle.
  // ---------------------------------------------------------------------------
  assign src1_haz = dec_src1_used && nz[dec_src1];
  assign src2_haz = dec_src2_used && nz[dec_src2];
  assign dst_full = dec_wb_wr && (pend[dec_dst] == CW'(MAX_PEND));

  assign issue_ready = (state_q == SB_RUN) && !src1_haz && !src2_haz && !dst_full;
  assign fire        = dec_valid && issue_ready;

  // ---------------------------------------------------------------------------
  // Branch-hold FSM and sticky error flag.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      SB_RUN: begin
        if (fire && dec_branch) begin
          state_d = SB_BRANCH;
        end
        // A resolution with no branch outstanding is a protocol error.
        if (wb_branch_done) begin
          err_d = 1'b1;
        end
      end
      SB_BRANCH: begin
        if (wb_branch_done) begin
          state_d = SB_RUN;
        end
      end
      default: state_d = SB_RUN;
    endcase
    if (|uf) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SB_RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign busy   = (|nz) || (state_q == SB_BRANCH);
  assign sb_err = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  import reg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic dec_valid, dec_src1_used, dec_src2_used, dec_wb_wr, dec_branch;
  reg_t dec_src1, dec_src2, dec_dst;
  logic issue_ready;
  logic wb_valid, wb_branch_done;
  reg_t wb_addr;
  logic busy, sb_err;

  int errors = 0;
  int checks = 0;

  // Expected {issue_ready, busy, sb_err} pushed when a step is driven and
  // popped when the DUT outputs for that step are sampled.
  typedef struct {
    string      tag;
    logic [2:0] exp;
  } sb_item_t;
  sb_item_t sbq[$];

  reg_scoreboard #(
    .REG_NUM     (32),
    .MAX_PEND    (3),
    .ZERO_REG_HW (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .dec_valid      (dec_valid),
    .dec_src1       (dec_src1),
    .dec_src2       (dec_src2),
    .dec_src1_used  (dec_src1_used),
    .dec_src2_used  (dec_src2_used),
    .dec_wb_wr      (dec_wb_wr),
    .dec_dst        (dec_dst),
    .dec_branch     (dec_branch),
    .issue_ready    (issue_ready),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .wb_branch_done (wb_branch_done),
    .busy           (busy),
    .sb_err         (sb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of sequence, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic idle();
    dec_valid = 0; dec_src1 = '0; dec_src2 = '0; dec_src1_used = 0; dec_src2_used = 0;
    dec_wb_wr = 0; dec_dst = '0; dec_branch = 0;
    wb_valid = 0; wb_addr = '0; wb_branch_done = 0;
  endtask

  task automatic dec_write(input int dst, input bit br);
    dec_valid = 1; dec_wb_wr = 1; dec_dst = reg_t'(dst); dec_branch = br;
    dec_src1_used = 0; dec_src2_used = 0;
  endtask

  task automatic dec_read(input int s1, input bit u1, input int s2, input bit u2);
    dec_valid = 1; dec_wb_wr = 0; dec_branch = 0;
    dec_src1 = reg_t'(s1); dec_src1_used = u1;
    dec_src2 = reg_t'(s2); dec_src2_used = u2;
  endtask

  task automatic wb(input bit v, input int a, input bit bd);
    wb_valid = v; wb_addr = reg_t'(a); wb_branch_done = bd;
  endtask

  task automatic push(input string tag, input bit rdy, input bit bsy, input bit err);
    sb_item_t it;
    it.tag = tag;
    it.exp = {rdy, bsy, err};
    sbq.push_back(it);
  endtask

  task automatic pop_compare();
    sb_item_t it;
    logic [2:0] obs;
    it = sbq.pop_front();
    obs = {issue_ready, busy, sb_err};
    checks++;
    assert (obs === it.exp) else begin
      errors++;
      $error("FAIL %s: observed rdy/busy/err=%b required %b", it.tag, obs, it.exp);
    end
  endtask

  // Push an expectation, sample at the falling edge, then advance one clock.
  task automatic step(input string tag, input bit rdy, input bit bsy, input bit err);
    push(tag, rdy, bsy, err);
    @(negedge clk);
    pop_compare();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    step("reset_state", 1, 0, 0);
    rst = 0;

    // RAW on r3: writeback in the same cycle does not release the reader.
    dec_write(3, 0);                     step("raw_alloc_r3", 1, 0, 0);
    dec_read(3, 1, 0, 0);                step("raw_stall_r3", 0, 1, 0);
    wb(1, 3, 0);                         step("raw_wb_same_cycle", 0, 1, 0);
    wb(0, 0, 0);                         step("raw_release_r3", 1, 0, 0);

    // src2 hazard, and an unused source never stalls.
    dec_write(10, 0);                    step("src2_alloc_r10", 1, 0, 0);
    dec_read(0, 0, 10, 1);               step("src2_stall_r10", 0, 1, 0);
    dec_read(0, 0, 10, 0); wb(1, 10, 0); step("src2_unused", 1, 1, 0);
    idle();                              step("src2_drained", 1, 0, 0);

    // WAW saturation at MAX_PEND on r5.
    dec_write(5, 0);                     step("waw_r5_1", 1, 0, 0);
    step("waw_r5_2", 1, 1, 0);
    step("waw_r5_3", 1, 1, 0);
    step("waw_r5_full", 0, 1, 0);
    wb(1, 5, 0);                         step("waw_r5_wb_same", 0, 1, 0);
    wb(0, 0, 0);                         step("waw_r5_4th_issues", 1, 1, 0);
    idle(); wb(1, 5, 0);                 step("waw_drain_1", 1, 1, 0);
    step("waw_drain_2", 1, 1, 0);
    step("waw_drain_3", 1, 1, 0);
    wb(0, 0, 0);                         step("waw_drained", 1, 0, 0);

    // Simultaneous increment and decrement on r7 starting from one pending.
    dec_write(7, 0);                     step("incdec_alloc_r7", 1, 0, 0);
    wb(1, 7, 0);                         step("incdec_same_cycle", 1, 1, 0);
    wb(0, 0, 0); dec_read(7, 1, 0, 0);   step("incdec_r7_still_1", 0, 1, 0);
    wb(1, 7, 0);                         step("incdec_last_wb", 0, 1, 0);
    wb(0, 0, 0);                         step("incdec_r7_clear", 1, 0, 0);

    // Branch hold for four cycles, released the cycle after resolution.
    idle(); dec_valid = 1; dec_branch = 1; step("br_fire", 1, 0, 0);
    dec_branch = 0;
    for (int i = 0; i < 4; i++) step($sformatf("br_hold_%0d", i), 0, 1, 0);
    wb(0, 0, 1);                         step("br_done_cycle", 0, 1, 0);
    wb(0, 0, 0);                         step("br_released", 1, 0, 0);

    // Resolution with no branch in flight: error, state stays in run.
    idle(); wb(0, 0, 1);                 step("stray_br_done", 1, 0, 0);
    wb(0, 0, 0);                         step("stray_br_err", 1, 0, 1);
    step("stray_br_err_sticky", 1, 0, 1);

    // Register zero is never tracked.
    dec_write(0, 0);                     step("r0_alloc", 1, 0, 1);
    dec_read(0, 1, 0, 1);                step("r0_no_stall", 1, 0, 1);

    // Asynchronous reset mid-branch with r4 outstanding.
    dec_write(4, 1);                     step("rst_br_fire", 1, 0, 1);
    idle(); dec_read(4, 1, 0, 0);        step("rst_br_hold", 0, 1, 1);
    rst = 1;
    push("rst_async_clear", 1, 0, 0);
    #1;
    pop_compare();
    @(posedge clk); #1;
    rst = 0;

    // Writeback for the pre-reset r4 now finds an empty counter.
    idle(); wb(1, 4, 0);                 step("post_rst_wb_r4", 1, 0, 0);
    wb(0, 0, 0);                         step("post_rst_wb_err", 1, 0, 1);

    // Underflow on r9 flags sb_err and it stays set; no stall results.
    wb(1, 9, 0);                         step("uf_r9", 1, 0, 1);
    wb(0, 0, 0); dec_read(9, 1, 0, 0);   step("uf_r9_sticky", 1, 0, 1);
    idle();                              step("uf_r9_sticky2", 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
